// File: rtl/chip_serializer_iq.sv
// chip_serializer_iq: maps 802.15.4 data symbols to 32-chip PN sequences
// and serialises them onto offset I/Q chip outputs (O-QPSK). Even chips go to
// i_chip and odd chips go to q_chip. Chip edges are spaced CLK_PER_CHIP
// cycles apart. This spacing gives Q its one-chip offset relative to I.
module chip_serializer_iq #(
  parameter int CLK_PER_CHIP = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sym_in,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic       i_chip,
  output logic       q_chip,
  output logic       chip_strobe,
  output logic [4:0] chip_idx,
  output logic       busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] CNT_LAST = 3'(CLK_PER_CHIP - 1);
  // Symbol 0 chip string, index 0 = c0 = first chip on air.
  localparam logic [0:31] SYM0_CHIPS = 32'b11011001110000110101001000101110;

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [4:0]  idx_reg, idx_next;
  logic [31:0] chips_reg, chips_next;
  logic        i_reg, i_next;
  logic        q_reg, q_next;
  logic        strobe_reg, strobe_next;
  logic [4:0]  chip_idx_reg, chip_idx_next;
  logic        busy_reg, busy_next;

  logic [31:0] sym_chips;
  logic        chip_edge;
  logic        last_chip;
  logic        accept;

  // Symbol k (0..7) is symbol 0 rotated right by 4k chips. Symbols 8..15
  // also invert every odd-indexed chip. The 5-bit subtraction wraps mod 32.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_map
      localparam logic ODD = 1'(gi % 2);
      logic [4:0] src;
      assign src = 5'(gi) - {sym_in[2:0], 2'b00};
      assign sym_chips[gi] = SYM0_CHIPS[src] ^ (sym_in[3] & ODD);
    end
  endgenerate

  assign chip_edge = (state_reg == RUN) && (cnt_reg == CNT_LAST);
  assign last_chip = chip_edge && (idx_reg == 5'd31);
  // Ready in IDLE, or on the last chip edge so back-to-back symbols add no gap.
  assign sym_ready = (state_reg == IDLE) || last_chip;
  assign accept    = sym_valid && sym_ready;

  assign i_chip      = i_reg;
  assign q_chip      = q_reg;
  assign chip_strobe = strobe_reg;
  assign chip_idx    = chip_idx_reg;
  assign busy        = busy_reg;

  // State and output registers; reset wins over any handshake or chip edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= 3'd0;
      idx_reg      <= 5'd0;
      chips_reg    <= 32'd0;
      i_reg        <= 1'b0;
      q_reg        <= 1'b0;
      strobe_reg   <= 1'b0;
      chip_idx_reg <= 5'd0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      chips_reg    <= chips_next;
      i_reg        <= i_next;
      q_reg        <= q_next;
      strobe_reg   <= strobe_next;
      chip_idx_reg <= chip_idx_next;
      busy_reg     <= busy_next;
    end
  end

  // Next-state logic: prescaler, chip issue and symbol hand-off.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    idx_next      = idx_reg;
    chips_next    = chips_reg;
    i_next        = i_reg;
    q_next        = q_reg;
    strobe_next   = 1'b0;
    chip_idx_next = chip_idx_reg;

    case (state_reg)
      IDLE: begin
        // Outputs settle to 0 one edge after the last chip has been held.
        i_next = 1'b0;
        q_next = 1'b0;
        if (accept) begin
          chips_next = sym_chips;
          cnt_next   = 3'd0;
          idx_next   = 5'd0;
          state_next = RUN;
        end
      end
      RUN: begin
        if (!chip_edge) begin
          cnt_next = cnt_reg + 3'd1;
        end else begin
          cnt_next      = 3'd0;
          strobe_next   = 1'b1;
          chip_idx_next = idx_reg;
          if (idx_reg[0]) q_next = chips_reg[idx_reg];
          else            i_next = chips_reg[idx_reg];
          // idx wraps 31 -> 0 naturally, ready for a chained symbol.
          idx_next = idx_reg + 5'd1;
          if (last_chip) begin
            if (accept) chips_next = sym_chips;
            else        state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next == RUN);
  end

endmodule

// File: tb/tb_chip_serializer_iq.sv
// Directed bench for chip_serializer_iq at CLK_PER_CHIP = 5, 2 and 8.
module tb_chip_serializer_iq;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sym_in;
  logic       valid5, valid2, valid8;
  logic       ready5, i5, q5, stb5, busy5;
  logic [4:0] cidx5;
  logic       ready2, i2, q2, stb2, busy2;
  logic [4:0] cidx2;
  logic       ready8, i8, q8, stb8, busy8;
  logic [4:0] cidx8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_cnt = 0;

  typedef struct {
    int         cyc;
    logic [4:0] idx;
    logic       i;
    logic       q;
  } strobe_t;
  strobe_t sq[$];

  always #5 clk = ~clk;

  chip_serializer_iq #(.CLK_PER_CHIP(5)) dut5 (
    .clk(clk), .reset(reset), .sym_in(sym_in), .sym_valid(valid5),
    .sym_ready(ready5), .i_chip(i5), .q_chip(q5), .chip_strobe(stb5),
    .chip_idx(cidx5), .busy(busy5));

  chip_serializer_iq #(.CLK_PER_CHIP(2)) dut2 (
    .clk(clk), .reset(reset), .sym_in(sym_in), .sym_valid(valid2),
    .sym_ready(ready2), .i_chip(i2), .q_chip(q2), .chip_strobe(stb2),
    .chip_idx(cidx2), .busy(busy2));

  chip_serializer_iq #(.CLK_PER_CHIP(8)) dut8 (
    .clk(clk), .reset(reset), .sym_in(sym_in), .sym_valid(valid8),
    .sym_ready(ready8), .i_chip(i8), .q_chip(q8), .chip_strobe(stb8),
    .chip_idx(cidx8), .busy(busy8));

  // Cycle counter: value after an edge identifies that edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe of the CLK_PER_CHIP=5 instance, and ready pulses in RUN.
  always @(negedge clk) begin
    if (stb5) sq.push_back('{cyc: cyc, idx: cidx5, i: i5, q: q5});
    if (busy5 && ready5) rdy_cnt <= rdy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference chip c[n] of symbol s, written as a plain rotation of the string.
  function automatic logic model_chip(input logic [3:0] s, input int n);
    logic [0:31] base;
    logic [4:0]  pos;
    base = 32'b11011001110000110101001000101110;
    pos  = 5'((((n - 4 * int'(s[2:0])) % 32) + 32) % 32);
    return base[pos] ^ (s[3] & (n % 2 == 1));
  endfunction

  // Offer a symbol to dut5 and return the cycle of the accepting edge.
  task automatic send5(input logic [3:0] s, input bit keep, output int acc);
    bit got = 0;
    acc = 0;
    @(posedge clk); #1;
    sym_in = s;
    valid5 = 1'b1;
    for (int t = 0; t < 400; t++) begin
      if (ready5) begin
        got = 1;
        @(posedge clk); #1;
        acc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) check("accept_timeout", 0, 1);
    $display("sent symbol %0d accepted at cycle %0d", s, acc);
    if (!keep) begin
      valid5 = 1'b0;
      sym_in = ~s;
    end
  endtask

  // Wait for dut5 to leave RUN, then check the hold and clear of the I/Q outputs.
  task automatic wait_idle(input string tag, input logic [3:0] s);
    for (int t = 0; t < 2000; t++) begin
      if (!busy5) break;
      @(posedge clk); #1;
    end
    check({tag, "_idle_timeout"}, 32'(busy5), 0);
    check({tag, "_hold_i"}, 32'(i5), 32'(model_chip(s, 30)));
    check({tag, "_hold_q"}, 32'(q5), 32'(model_chip(s, 31)));
    @(posedge clk); #1;
    check({tag, "_clear_iq"}, 32'({i5, q5}), 0);
    check({tag, "_idle_ready"}, 32'(ready5), 1);
  endtask

  task automatic check_stream(input string tag, input int acc, input logic [3:0] sa,
                              input logic [3:0] sb, input int nsym);
    int bad_idx = 0;
    int bad_gap = 0;
    int bad_chip = 0;
    int bad_hold = 0;
    logic pi = 1'b0;
    logic pq = 1'b0;
    logic [3:0] s;
    logic e;
    check({tag, "_count"}, 32'(sq.size()), 32'(32 * nsym));
    if (sq.size() > 0) check({tag, "_latency"}, 32'(sq[0].cyc - acc), 5);
    foreach (sq[j]) begin
      if (sq[j].idx != 5'(j % 32)) bad_idx++;
      if (j > 0 && (sq[j].cyc - sq[j-1].cyc) != 5) bad_gap++;
      s = (j < 32) ? sa : sb;
      e = model_chip(s, j % 32);
      if (j % 2 == 0) begin
        if (sq[j].i !== e) bad_chip++;
        if (sq[j].q !== pq) bad_hold++;
      end else begin
        if (sq[j].q !== e) bad_chip++;
        if (sq[j].i !== pi) bad_hold++;
      end
      pi = sq[j].i;
      pq = sq[j].q;
    end
    check({tag, "_idx_errs"}, 32'(bad_idx), 0);
    check({tag, "_gap_errs"}, 32'(bad_gap), 0);
    check({tag, "_chip_errs"}, 32'(bad_chip), 0);
    check({tag, "_hold_errs"}, 32'(bad_hold), 0);
  endtask

  // Compare the first symbol's I and Q sequences with hand-derived strings.
  task automatic seq_check(input string tag, input logic [15:0] exp_i, input logic [15:0] exp_q);
    logic [15:0] si = 16'd0;
    logic [15:0] sqq = 16'd0;
    if (sq.size() >= 32) begin
      for (int j = 0; j < 32; j++) begin
        if (j % 2 == 0) si  = {si[14:0], sq[j].i};
        else            sqq = {sqq[14:0], sq[j].q};
      end
    end
    check({tag, "_i_seq"}, 32'(si), 32'(exp_i));
    check({tag, "_q_seq"}, 32'(sqq), 32'(exp_q));
  endtask

  // One symbol on the 2- or 8-cycle instance: first-chip latency and spacing.
  task automatic run_small(input int cpc);
    int acc;
    int sc[3];
    int found = 0;
    logic stb;
    @(posedge clk); #1;
    sym_in = 4'd5;
    if (cpc == 2) valid2 = 1'b1; else valid8 = 1'b1;
    check($sformatf("cpc%0d_ready", cpc), 32'(cpc == 2 ? ready2 : ready8), 1);
    @(posedge clk); #1;
    acc = cyc;
    valid2 = 1'b0;
    valid8 = 1'b0;
    $display("sent symbol 5 to cpc=%0d instance at cycle %0d", cpc, acc);
    for (int t = 0; t < 100 && found < 3; t++) begin
      @(posedge clk); #1;
      stb = (cpc == 2) ? stb2 : stb8;
      if (stb) begin
        sc[found] = cyc;
        found++;
      end
    end
    check($sformatf("cpc%0d_strobes", cpc), 32'(found), 3);
    if (found == 3) begin
      check($sformatf("cpc%0d_latency", cpc), 32'(sc[0] - acc), 32'(cpc));
      check($sformatf("cpc%0d_gap1", cpc), 32'(sc[1] - sc[0]), 32'(cpc));
      check($sformatf("cpc%0d_gap2", cpc), 32'(sc[2] - sc[1]), 32'(cpc));
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2;
    bit hit;
    reset  = 1'b0;
    sym_in = 4'd0;
    valid5 = 1'b1;
    valid2 = 1'b0;
    valid8 = 1'b0;

    // Reset held with sym_valid high.
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", 32'({i5, q5, stb5, cidx5, busy5}), 0);
    check("rst_ready", 32'(ready5), 1);
    reset  = 1'b1;
    valid5 = 1'b0;
    @(posedge clk); #1;
    check("post_rst_busy", 32'(busy5), 0);
    check("post_rst_ready", 32'(ready5), 1);

    // Symbol 0.
    sq.delete();
    send5(4'd0, 0, acc);
    wait_idle("sym0", 4'd0);
    check_stream("sym0", acc, 4'd0, 4'd0, 1);
    seq_check("sym0", 16'b1010100100010111, 16'b1101100111000010);

    // Symbol 8: same I chips, inverted Q chips.
    sq.delete();
    send5(4'd8, 0, acc);
    wait_idle("sym8", 4'd8);
    check_stream("sym8", acc, 4'd8, 4'd8, 1);
    seq_check("sym8", 16'b1010100100010111, 16'b0010011000111101);

    // Symbols 1 then 15, valid held back-to-back.
    sq.delete();
    @(negedge clk);
    rdy_cnt = 0;
    send5(4'd1, 1, acc);
    send5(4'd15, 0, acc2);
    wait_idle("b2b", 4'd15);
    check_stream("b2b", acc, 4'd1, 4'd15, 2);
    check("b2b_chain_gap", 32'(acc2 - acc), 32'(32 * 5));
    check("b2b_ready_pulses", 32'(rdy_cnt), 2);

    // Reset right after chip 17 of symbol 3.
    sq.delete();
    send5(4'd3, 0, acc);
    hit = 0;
    for (int t = 0; t < 300; t++) begin
      if (stb5 && cidx5 == 5'd17) begin
        hit = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("mid_hit17", 32'(hit), 1);
    check("mid_ready_low", 32'(ready5), 0);
    reset  = 1'b0;
    valid5 = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_outs", 32'({i5, q5, stb5, cidx5, busy5}), 0);
    @(posedge clk); #1;
    reset  = 1'b1;
    valid5 = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("mid_no_strobes", 32'(sq.size()), 18);
    check("mid_idle", 32'({busy5, i5, q5}), 0);
    sq.delete();
    send5(4'd0, 0, acc);
    wait_idle("after_rst", 4'd0);
    check_stream("after_rst", acc, 4'd0, 4'd0, 1);

    // Other prescaler settings.
    run_small(2);
    run_small(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
